// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI-mode (mode 0) command engine: frames one command, polls for and collects its response.
// Define SD_CMD_CRC7_EN to compute a real CRC7 for every command; otherwise a small CRC table is used.
module sd_spi_cmd_engine #(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 8,
    parameter int RESP_MAX     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [5:0]            cmd_index,
    input  logic [31:0]           cmd_arg,
    input  logic [2:0]            resp_len,
    output logic                  resp_valid,
    output logic                  resp_timeout,
    output logic [8*RESP_MAX-1:0] resp_data,
    output logic                  busy,
    output logic                  sd_ck,
    output logic                  sd_cs_n,
    output logic                  sd_mosi,
    input  logic                  sd_miso
);

    localparam int RW = 8 * RESP_MAX;
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, PRE, CMD, WAIT, RESP, POST, DONE} state_t;

    // Handshake: a command transfers on the clk edge where cmd_valid & cmd_ready are both high.
    state_t        state;
    logic [DW-1:0] div_cnt;
    logic          ph;
    logic [5:0]    bit_cnt;
    logic [5:0]    bit_last;
    logic [54:0]   tx_sr;
    logic [7:0]    rx_sr;
    logic [2:0]    len_q;
    logic [2:0]    rem;
    logic [7:0]    wait_cnt;

    logic [39:0]   hdr;
    logic [6:0]    crc;
    logic [2:0]    len_eff;
    logic          tick;
    logic          seg_end;
    logic [RW+7:0] resp_shift;

    assign hdr        = {2'b01, cmd_index, cmd_arg};
    assign tick       = (div_cnt == DW'(CLK_DIV - 1));
    assign seg_end    = tick && ph && (bit_cnt == bit_last);
    assign resp_shift = {resp_data, rx_sr};
    assign len_eff    = (resp_len == 3'd0) ? 3'd1 :
                        (resp_len > 3'(RESP_MAX)) ? 3'(RESP_MAX) : resp_len;

    always_comb begin
        crc = 7'h00;
`ifdef SD_CMD_CRC7_EN
        for (int i = 39; i >= 0; i--) begin
            crc = {crc[5:0], 1'b0} ^ ((hdr[i] ^ crc[6]) ? 7'h09 : 7'h00);
        end
`else
        case (cmd_index)
            6'd0:    crc = 7'h4A;
            6'd8:    crc = 7'h43;
            default: crc = 7'h00;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            ph           <= 1'b0;
            bit_cnt      <= '0;
            bit_last     <= 6'd7;
            tx_sr        <= '1;
            rx_sr        <= '1;
            len_q        <= 3'd1;
            rem          <= 3'd0;
            wait_cnt     <= 8'd0;
            cmd_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            resp_data    <= '0;
            busy         <= 1'b0;
            sd_ck        <= 1'b0;
            sd_cs_n      <= 1'b1;
            sd_mosi      <= 1'b1;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        // Leading 0xFF pre-byte plus frame; shifting fills with 1s, so later bytes are 0xFF.
                        tx_sr        <= {7'h7F, hdr, crc, 1'b1};
                        sd_mosi      <= 1'b1;
                        len_q        <= len_eff;
                        resp_data    <= '0;
                        resp_timeout <= 1'b0;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        sd_cs_n      <= 1'b0;
                        div_cnt      <= '0;
                        ph           <= 1'b0;
                        bit_cnt      <= '0;
                        bit_last     <= 6'd7;
                        state        <= PRE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!ph) begin
                            sd_ck <= 1'b1;
                            ph    <= 1'b1;
                            rx_sr <= {rx_sr[6:0], sd_miso};
                        end else begin
                            sd_ck   <= 1'b0;
                            ph      <= 1'b0;
                            sd_mosi <= tx_sr[54];
                            tx_sr   <= {tx_sr[53:0], 1'b1};
                            bit_cnt <= seg_end ? 6'd0 : bit_cnt + 1'b1;
                        end
                    end
                    if (seg_end) begin
                        case (state)
                            PRE: begin
                                bit_last <= 6'd47;
                                state    <= CMD;
                            end
                            CMD: begin
                                bit_last <= 6'd7;
                                wait_cnt <= 8'd0;
                                state    <= WAIT;
                            end
                            WAIT: begin
                                if (!rx_sr[7]) begin
                                    resp_data <= resp_shift[RW-1:0];
                                    rem       <= len_q - 3'd1;
                                    state     <= (len_q > 3'd1) ? RESP : POST;
                                end else if (wait_cnt == 8'(RESP_TIMEOUT - 1)) begin
                                    resp_timeout <= 1'b1;
                                    resp_data    <= RW'(8'hFF);
                                    state        <= POST;
                                end else begin
                                    wait_cnt <= wait_cnt + 8'd1;
                                end
                            end
                            RESP: begin
                                resp_data <= resp_shift[RW-1:0];
                                rem       <= rem - 3'd1;
                                if (rem == 3'd1) state <= POST;
                            end
                            default: begin
                                sd_cs_n    <= 1'b1;
                                sd_mosi    <= 1'b1;
                                resp_valid <= 1'b1;
                                state      <= DONE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: card model on the SPI pins, MOSI-byte and response scoreboards.
`timescale 1ns/1ps
module tb_sd_spi_cmd_engine;

  localparam int CLK_DIV      = 4;
  localparam int RESP_TIMEOUT = 8;
  localparam int RESP_MAX     = 5;

`ifdef SD_CMD_CRC7_EN
  localparam logic [7:0] CRC17 = 8'h55;
  localparam logic [7:0] CRC55 = 8'h65;
`else
  localparam logic [7:0] CRC17 = 8'h01;
  localparam logic [7:0] CRC55 = 8'h01;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [5:0]            cmd_index = 6'd0;
  logic [31:0]           cmd_arg = 32'd0;
  logic [2:0]            resp_len = 3'd1;
  logic                  resp_valid;
  logic                  resp_timeout;
  logic [8*RESP_MAX-1:0] resp_data;
  logic                  busy;
  logic                  sd_ck;
  logic                  sd_cs_n;
  logic                  sd_mosi;
  logic                  sd_miso = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_mosi_q[$];
  logic [40:0] exp_resp_q[$];
  logic [7:0]  card_q[$];
  logic [39:0] last_resp = '0;
  bit          mon_en = 1'b1;
  int          rise_cnt = 0;
  logic [7:0]  mosi_sr = 8'hFF;
  time         t1, t2, t8, t56;

  sd_spi_cmd_engine #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT), .RESP_MAX(RESP_MAX)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_len(resp_len),
    .resp_valid(resp_valid), .resp_timeout(resp_timeout), .resp_data(resp_data),
    .busy(busy), .sd_ck(sd_ck), .sd_cs_n(sd_cs_n), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // card side: collect MOSI bytes on rising sd_ck, compare against the expected byte queue
  always @(posedge sd_ck or posedge sd_cs_n) begin
    if (sd_cs_n) begin
      rise_cnt = 0;
    end else begin
      mosi_sr = {mosi_sr[6:0], sd_mosi};
      rise_cnt++;
      if (rise_cnt == 1) t1 = $time;
      if (rise_cnt == 2) t2 = $time;
      if (rise_cnt == 8) t8 = $time;
      if (rise_cnt == 56) t56 = $time;
      if (mon_en && (rise_cnt % 8 == 0)) begin
        if (exp_mosi_q.size() == 0) check("mosi_extra", 64'(mosi_sr), 64'h100);
        else check("mosi_byte", 64'(mosi_sr), 64'(exp_mosi_q.pop_front()));
      end
    end
  end

  // card side: drive MISO on falling sd_ck, starting right after the 7 command-phase bytes
  always @(negedge sd_ck) begin
    int k;
    logic [7:0] b;
    k = rise_cnt - 56;
    if (k >= 0) begin
      b = (k / 8 < card_q.size()) ? card_q[k / 8] : 8'hFF;
      sd_miso = b[7 - (k % 8)];
    end else begin
      sd_miso = 1'b1;
    end
  end

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] len,
                          input logic [7:0] crc_b, input int nw, input int nr,
                          input logic [39:0] rdata, input bit poke);
    int eff, polled, nbytes, lat;
    bit to, seen;
    logic [39:0] acc;
    logic [7:0]  b;
    logic [47:0] frame;
    logic [40:0] e;
    eff = (len == 0) ? 1 : ((int'(len) > RESP_MAX) ? RESP_MAX : int'(len));
    card_q.delete();
    for (int j = 0; j < nw; j++) card_q.push_back(8'hFF);
    for (int j = 0; j < nr; j++) card_q.push_back(rdata[8*(nr-1-j) +: 8]);
    to = (nr == 0) || (nw >= RESP_TIMEOUT);
    acc = '0;
    if (to) acc = 40'hFF;
    else for (int j = 0; j < eff; j++) begin
      b = (j < nr) ? rdata[8*(nr-1-j) +: 8] : 8'hFF;
      acc = {acc[31:0], b};
    end
    polled = to ? RESP_TIMEOUT : nw + eff;
    nbytes = 7 + polled + 1;
    frame = {2'b01, idx, arg, crc_b};
    exp_mosi_q.push_back(8'hFF);
    for (int j = 0; j < 6; j++) exp_mosi_q.push_back(frame[8*(5-j) +: 8]);
    for (int j = 0; j < polled + 1; j++) exp_mosi_q.push_back(8'hFF);
    exp_resp_q.push_back({to, acc});

    for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
    check("ready_wait", 64'(cmd_ready), 64'd1);
    check("resp_held", 64'(resp_data), 64'(last_resp));
    cmd_index = idx; cmd_arg = arg; resp_len = len; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("busy_on", 64'(busy), 64'd1);
        check("cs_low", 64'(sd_cs_n), 64'd0);
        check("resp_clear", 64'(resp_data), 64'd0);
      end
      if (poke && lat == 100) begin
        cmd_index = 6'd17; cmd_valid = 1'b1;
      end
      if (poke && lat > 100 && lat < 105) check("ready_busy", 64'(cmd_ready), 64'd0);
      if (poke && lat == 105) cmd_valid = 1'b0;
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      check("resp_wait", 64'd0, 64'd1);
      exp_mosi_q.delete();
      exp_resp_q.delete();
      return;
    end
    check("latency", 64'(lat), 64'(nbytes * 16 * CLK_DIV + 1));
    check("cs_released", 64'(sd_cs_n), 64'd1);
    e = exp_resp_q.pop_front();
    check("resp_timeout", 64'(resp_timeout), 64'(e[40]));
    check("resp_data", 64'(resp_data), 64'(e[39:0]));
    last_resp = e[39:0];
    @(negedge clk);
    check("rv_pulse", 64'(resp_valid), 64'd0);
    check("ready_back", 64'(cmd_ready), 64'd1);
    check("busy_off", 64'(busy), 64'd0);
    check("mosi_left", 64'(exp_mosi_q.size()), 64'd0);
    exp_mosi_q.delete();
  endtask

  initial begin
    logic [39:0] r;
    int len;
    // reset
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_rv", 64'(resp_valid), 64'd0);
    check("rst_to", 64'(resp_timeout), 64'd0);
    check("rst_data", 64'(resp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ck", 64'(sd_ck), 64'd0);
    check("rst_cs", 64'(sd_cs_n), 64'd1);
    check("rst_mosi", 64'(sd_mosi), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    send_cmd(6'd0, 32'h0, 3'd1, 8'h95, 2, 1, 40'h01, 1'b0);
    send_cmd(6'd8, 32'h1AA, 3'd5, 8'h87, 1, 5, 40'h01000001AA, 1'b1);
    check("ck_period", 64'(t2 - t1), 64'(2 * CLK_DIV * 10));
    check("cmd_phase", 64'(t56 - t8), 64'(48 * 2 * CLK_DIV * 10));
    send_cmd(6'd55, 32'h0, 3'd1, CRC55, 0, 0, 40'h0, 1'b0);
    send_cmd(6'd17, 32'h0, 3'd1, CRC17, 0, 1, 40'h00, 1'b0);

    // reset during the command phase
    mon_en = 1'b0;
    card_q.delete();
    @(negedge clk);
    cmd_index = 6'd17; cmd_arg = 32'h0; resp_len = 3'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 3000 && rise_cnt < 20; k++) @(negedge clk);
    check("reached_cmd", 64'(rise_cnt >= 20), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_cs", 64'(sd_cs_n), 64'd1);
    check("mid_rst_ck", 64'(sd_ck), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd0);
    check("mid_rst_mosi", 64'(sd_mosi), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_data", 64'(resp_data), 64'd0);
    exp_mosi_q.delete();
    last_resp = '0;
    mon_en = 1'b1;

    send_cmd(6'd0, 32'h0, 3'd1, 8'h95, 0, 1, 40'h01, 1'b0);
    send_cmd(6'd55, 32'h0, 3'd0, CRC55, 3, 1, 40'h01, 1'b0);
    send_cmd(6'd8, 32'h1AA, 3'd7, 8'h87, 0, 5, 40'h00123456A5, 1'b0);
    send_cmd(6'd55, 32'h0, 3'd1, CRC55, RESP_TIMEOUT - 1, 1, 40'h05, 1'b0);
    send_cmd(6'd55, 32'h0, 3'd1, CRC55, RESP_TIMEOUT, 1, 40'h05, 1'b0);
    for (int i = 0; i < 4; i++) begin
      len = $urandom_range(1, RESP_MAX);
      r = 40'({$urandom(), $urandom()});
      r[8*len-1] = 1'b0;
      send_cmd(6'd55, 32'h0, 3'(len), CRC55, $urandom_range(0, RESP_TIMEOUT - 1), len, r, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_spi_cmd_engine.md
Name: sd_spi_cmd_engine

Overview:
- Parametrised SD-card SPI-mode command engine; successor to the fixed-rate command logic inside SD_TOP.
- Accepts one command request (index, argument, expected response length) and drives SD_CK/CS/MOSI.
- Collects R1 or R3/R7 responses from MISO, with a programmable response timeout.
- Sits between the init/read FSMs and the card pins; shared by initialisation and data-path sequencers.

Parameters:
- CLK_DIV, 4: clk cycles per SD_CK half-period; legal range ≥2.
- RESP_TIMEOUT, 8: max 0xFF bytes polled while waiting for the response start; legal range 1..255.
- RESP_MAX, 5: max response bytes (1 = R1 only, 5 = R3/R7).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; transfer occurs when cmd_valid & cmd_ready.
- cmd_index  in  6  SD command index.
- cmd_arg  in  32  command argument.
- resp_len  in  3  expected response bytes, 1..RESP_MAX; latched with the command.
- resp_valid  out  1  one-clk pulse when the command completes.
- resp_timeout  out  1  qualifies resp_valid; no response start seen.
- resp_data  out  8*RESP_MAX  response bytes; first byte received in the MSBs of the used span, right-aligned.
- busy  out  1  high whenever not IDLE.
- sd_ck  out  1  SPI clock; idles low.
- sd_cs_n  out  1  chip select, active low.
- sd_mosi  out  1  serial data to card.
- sd_miso  in  1  serial data from card.

Behaviour:
- Clock and reset: single clock domain clk; rst is asynchronous, active-high.
- Reset values: cmd_ready=0 during reset (1 after, in IDLE); resp_valid=0; resp_timeout=0; resp_data=0; busy=0; sd_ck=0; sd_cs_n=1; sd_mosi=1.
- SPI mode 0:
  - MOSI changes on the SD_CK falling edge (first bit set before the first rising edge); MISO sampled on the rising edge.
  - sd_ck toggles every CLK_DIV clk cycles.
  - One byte takes 16*CLK_DIV clk cycles, MSB first.
- FSM states: IDLE, PRE, CMD, WAIT, RESP, POST, DONE.
  - IDLE: on handshake, latch index/arg/resp_len, assert sd_cs_n=0, go to PRE.
  - PRE: clock one 0xFF byte, then go to CMD.
  - CMD: shift 48 bits: {2'b01, cmd_index, cmd_arg, crc7, 1'b1}.
  - WAIT: clock 0xFF bytes and sample each received byte.
    - First byte with bit7=0 is response byte 0: store it; go to RESP if resp_len>1, else POST.
    - After RESP_TIMEOUT bytes with no start: set timeout flag, resp_data[7:0]=0xFF, go to POST.
  - RESP: clock resp_len-1 further 0xFF bytes and store each.
  - POST: clock one 0xFF byte with CS low, then sd_cs_n=1, go to DONE.
  - DONE: pulse resp_valid (resp_timeout valid the same cycle), return to IDLE.
- Command latency, no timeout: (1 + 6 + n_wait + resp_len + 1) bytes + 1 clk.
- resp_data holds its value until the next command is accepted, then clears to 0.
- resp_len out of range: 0 is treated as 1; values above RESP_MAX are clamped to RESP_MAX.
- cmd_valid while busy: ignored (cmd_ready=0); no queueing.
- Reset mid-command: all outputs return to reset values immediately; sd_cs_n=1, sd_ck=0; any partial response is discarded.
- sd_mosi is held 1 whenever no command bit is being driven.

Optional Feature:
- Macro: SD_CMD_CRC7_EN.
- Defined: crc7 is computed over the first 40 frame bits (polynomial x^7+x^3+1), so every command carries a valid CRC.
- Undefined: crc7 comes from a table:
  - 0x4A for index 0 (frame byte 0x95);
  - 0x43 for index 8 (frame byte 0x87);
  - 0x00 otherwise (frame byte 0x01).

Test Plan:
- CMD0, arg 0, resp_len 1; model returns 0xFF, 0xFF, then 0x01 -> MOSI bytes FF,40,00,00,00,00,95; resp_data[7:0]=0x01; resp_timeout=0; one resp_valid pulse; sd_cs_n high after the trailing FF.
- CMD8, arg 0x000001AA, resp_len 5; model replies 01 00 00 01 AA -> frame 48 00 00 01 AA 87; resp_data=0x01000001AA.
- MISO held 1, RESP_TIMEOUT=8 -> exactly 8 polling bytes; resp_valid with resp_timeout=1 and resp_data[7:0]=0xFF; CS released.
- CLK_DIV=4 -> sd_ck period 8 clk; complete 48-bit command phase lasts 384 clk; cmd_ready low throughout; a second cmd_valid is ignored.
- rst pulsed during CMD phase -> sd_cs_n=1, sd_ck=0, busy=0 asynchronously; the next command completes normally.
- SD_CMD_CRC7_EN defined, CMD17 arg 0 -> CRC byte 0x55; undefined -> 0x01.
